wb_sched: RTL and testbench

WB_SCHED -- requirements
Module: wb_sched

---
 rtl/wb_sched.sv | 155 +++++++++++++++
 tb/tb_wb_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_sched.sv
// Writeback scheduler: merges pipeline writes and queued muldiv results onto one regfile port.
// Optional starvation guard (counter + hold_pipe) is built only with WB_SCHED_STARVE_EN defined.
module wb_sched #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_res,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_res,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic [4:0]  dst,
    output logic        busy,
    output logic        hold_pipe,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pend
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("wb_sched: STARVE_LIMIT must be within 1..15");
    end

    logic [4:0]  r_q_rd  [2];
    logic [31:0] r_q_res [2];
    logic        r_head;
    logic [1:0]  r_count;

    logic        r_rf_we;
    logic        r_rf_src_md;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;
    logic [31:0] r_pend;

    logic        w_push;
    logic        w_pop;
    logic        w_tail;
    logic        w_sel_valid;
    logic [4:0]  w_sel_rd;
    logic [31:0] w_sel_res;
    logic [31:0] w_pend_next;
    logic        w_md_hit;

    assign md_ready = (r_count != 2'd2);
    assign w_push   = md_valid && md_ready;
    // The pipeline always wins; the queue head only drains in pipeline-idle cycles.
    assign w_pop    = !pipe_valid && (r_count != 2'd0);
    assign w_tail   = r_head ^ r_count[0];

    assign w_sel_valid = pipe_valid || (r_count != 2'd0);
    assign w_sel_rd    = pipe_valid ? pipe_rd  : r_q_rd[r_head];
    assign w_sel_res   = pipe_valid ? pipe_res : r_q_res[r_head];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[w_tail]  <= md_rd;
            r_q_res[w_tail] <= md_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            r_head  <= r_head ^ w_pop;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we     <= 1'b0;
            r_rf_src_md <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
        end else begin
            r_rf_we     <= w_sel_valid && (w_sel_rd != 5'd0);
            r_rf_src_md <= w_pop;
            if (w_sel_valid) begin
                r_rf_waddr <= w_sel_rd;
                r_rf_wdata <= w_sel_res;
            end
        end
    end

    // A committed muldiv write releases its register; a same-edge issue re-reserves it.
    always_comb begin
        w_pend_next = r_pend;
        if (r_rf_we && r_rf_src_md) begin
            w_pend_next[r_rf_waddr] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            w_pend_next[issue_rd] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign w_md_hit = r_rf_we && r_rf_src_md &&
                      (((src1 == r_rf_waddr) && (src1 != 5'd0)) ||
                       ((src2 == r_rf_waddr) && (src2 != 5'd0)) ||
                       ((dst  == r_rf_waddr) && (dst  != 5'd0)));
    assign busy = r_pend[src1] | r_pend[src2] | r_pend[dst] | w_md_hit;

`ifdef WB_SCHED_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve;
    logic [3:0] w_starve_next;
    logic       r_hold;

    always_comb begin
        w_starve_next = '0;
        if ((r_count != 2'd0) && pipe_valid) begin
            w_starve_next = (r_starve == LIMIT) ? r_starve : r_starve + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
            r_hold   <= 1'b0;
        end else begin
            r_starve <= w_starve_next;
            r_hold   <= (w_starve_next == LIMIT) && (r_starve != LIMIT);
        end
    end

    assign hold_pipe = r_hold;
`else
    assign hold_pipe = 1'b0;
`endif

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign pend     = r_pend;

endmodule

// File: tb/tb_wb_sched.sv
// Bench for wb_sched: directed scenarios followed by random traffic, all checked
// against a queue-based model of the writeback rules.
module tb_wb_sched;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_res;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_res;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  src1, src2, dst;
    logic        busy;
    logic        hold_pipe;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend;

    always #5 clk = ~clk;

    wb_sched #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_res(pipe_res),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_res(md_res),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .src1(src1), .src2(src2), .dst(dst),
        .busy(busy), .hold_pipe(hold_pipe),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend(pend)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pend;
    logic        m_we;
    logic        m_src_md;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_starve;
    logic        m_hold;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic model_busy(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        logic hit;
        hit = m_we && m_src_md &&
              ((s1 == m_waddr && s1 != 0) || (s2 == m_waddr && s2 != 0) || (d == m_waddr && d != 0));
        return m_pend[s1] | m_pend[s2] | m_pend[d] | hit;
    endfunction

    // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
    task automatic step(input logic r, input logic pv, input logic [4:0] prd, input logic [31:0] pres,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mres,
                        input logic iv, input logic [4:0] ird,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        logic        had, ready;
        logic [31:0] new_pend;
        ent_t        e;
        int          old;
        rst = r; pipe_valid = pv; pipe_rd = prd; pipe_res = pres;
        md_valid = mv; md_rd = mrd; md_res = mres;
        issue_valid = iv; issue_rd = ird; src1 = s1; src2 = s2; dst = d;
        #1;
        if (!r) begin
            chk("md_ready", {31'd0, md_ready}, {31'd0, m_q.size() < 2});
            chk("busy", {31'd0, busy}, {31'd0, model_busy(s1, s2, d)});
        end
        if (r) begin
            m_q.delete();
            m_pend = '0; m_we = 0; m_src_md = 0; m_waddr = '0; m_wdata = '0;
            m_starve = 0; m_hold = 0;
        end else begin
            had   = (m_q.size() != 0);
            ready = (m_q.size() < 2);
            new_pend = m_pend;
            if (m_we && m_src_md) new_pend[m_waddr] = 1'b0;
            if (iv && ird != 0) new_pend[ird] = 1'b1;
            if (pv) begin
                m_we = (prd != 0); m_src_md = 0; m_waddr = prd; m_wdata = pres;
            end else if (had) begin
                e = m_q.pop_front();
                m_we = (e.rd != 0); m_src_md = 1; m_waddr = e.rd; m_wdata = e.res;
            end else begin
                m_we = 0; m_src_md = 0;
            end
            if (mv && ready) m_q.push_back('{rd: mrd, res: mres});
            m_pend = new_pend;
`ifdef WB_SCHED_STARVE_EN
            old = m_starve;
            m_starve = (had && pv) ? ((old + 1 > LIMIT) ? LIMIT : old + 1) : 0;
            m_hold = (m_starve == LIMIT) && (old != LIMIT);
`else
            old = 0;
            m_hold = 0;
`endif
        end
        @(posedge clk);
        #1;
        chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
        if (m_we) begin
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
            chk("rf_wdata", rf_wdata, m_wdata);
        end
        chk("pend", pend, m_pend);
        chk("hold_pipe", {31'd0, hold_pipe}, {31'd0, m_hold});
        $display("t=%0t rst=%0b pv=%0b mv=%0b iv=%0b -> rf_we=%0b waddr=%0d wdata=%h pend=%h hold=%0b q=%0d",
                 $time, r, pv, mv, iv, rf_we, rf_waddr, rf_wdata, pend, hold_pipe, m_q.size());
    endtask

    task automatic idle(input int n, input logic [4:0] s1);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, s1, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("reset_wdata", rf_wdata, 32'd0);

        // Pipeline write, latency 1
        step(0, 1, 5'd5, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pipe_wdata", rf_wdata, 32'h11);
        idle(1, 0);
        chk("pipe_we_drop", {31'd0, rf_we}, 32'd0);

        // Scoreboard and muldiv writeback to r7
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 0);
        chk("pend7_set", {31'd0, pend[7]}, 32'd1);
        step(0, 0, 0, 0, 1, 5'd7, 32'hDEAD, 0, 0, 5'd7, 0, 0);
        idle(1, 5'd7);
        chk("md_write", rf_wdata, 32'hDEAD);
        idle(2, 5'd7);
        chk("pend7_clr", {31'd0, pend[7]}, 32'd0);

        // Queue fills while pipeline hogs the port; third offer stalls
        step(0, 1, 5'd1, 32'h101, 1, 5'd2, 32'h202, 0, 0, 0, 0, 0);
        step(0, 1, 5'd1, 32'h102, 1, 5'd3, 32'h303, 0, 0, 0, 0, 0);
        step(0, 1, 5'd1, 32'h103, 1, 5'd4, 32'h404, 0, 0, 0, 0, 0);
        chk("full_not_ready", {31'd0, md_ready}, 32'd0);
        step(0, 0, 0, 0, 1, 5'd4, 32'h404, 0, 0, 0, 0, 0);
        idle(4, 0);

        // Starvation: one queued entry, pipeline busy for LIMIT cycles
        step(0, 1, 5'd6, 32'h600, 1, 5'd8, 32'h808, 0, 0, 0, 0, 0);
        for (int k = 0; k < LIMIT; k++) step(0, 1, 5'd6, 32'h600 + k, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, !m_hold, 5'd6, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3, 0);

        // rd=0 result is drained silently
        step(0, 0, 0, 0, 1, 5'd0, 32'h1, 0, 0, 0, 0, 0);
        idle(3, 0);

        // Reset with two queued entries and a write in flight
        step(0, 1, 5'd3, 32'h33, 1, 5'd10, 32'hA0, 1, 5'd9, 0, 0, 0);
        step(0, 1, 5'd3, 32'h34, 1, 5'd11, 32'hB0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_md_ready", {31'd0, md_ready}, 32'd1);
        chk("rst_pend", pend, 32'd0);
        idle(3, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) == 0),
                 m_hold ? 1'b0 : ($urandom_range(0, 99) < 55),
                 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
